ecc_secded_stream: RTL and testbench

- Parametrised, pipelined SEC-DED (extended Hamming) codec that succeeds the fixed 8/16/32-bit ECC encoder/decoder.
- Supports any DATA_WIDTH from 4 to 64. Modes are selected per beat: encode, decode, or full-channel (encode, XOR noise, decode).
- Uses valid/ready streaming in place of register-triggered start, so it sits between the APB register file and any consumer and accepts one beat per cycle.
- Keeps saturating single-error and double-error statistics counters.

---
 rtl/ecc_secded_stream.sv | 212 +++++++++++++++++++++
 tb/tb_ecc_secded_stream.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_secded_stream.sv
// ecc_secded_stream: parametrised two-stage SEC-DED (extended Hamming) codec.
// Each beat selects encode, decode, or full-channel mode (encode, XOR noise, decode).
// Streams over valid/ready and keeps saturating single/double error counters.
module ecc_secded_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    localparam int P  = (DATA_WIDTH <= 32'sd4)  ? 32'sd3 :
                        (DATA_WIDTH <= 32'sd11) ? 32'sd4 :
                        (DATA_WIDTH <= 32'sd26) ? 32'sd5 :
                        (DATA_WIDTH <= 32'sd57) ? 32'sd6 : 32'sd7,
    localparam int CW = DATA_WIDTH + P + 32'sd1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_mode,
    input  logic [CW-1:0]        in_data,
    input  logic [CW-1:0]        in_noise,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_data,
    output logic [1:0]           out_num_errors,
    input  logic                 cnt_clear,
    output logic [CNT_WIDTH-1:0] cnt_single,
    output logic [CNT_WIDTH-1:0] cnt_double
);

    localparam logic [1:0] MODE_ENC   = 2'b00;
    localparam logic [1:0] MODE_DEC   = 2'b01;
    localparam logic [1:0] MODE_FULL  = 2'b10;
    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_SINGLE = 2'b01;
    localparam logic [1:0] ERR_DOUBLE = 2'b10;
    localparam logic [1:0] ERR_RSV    = 2'b11;

    localparam logic [P-1:0]         ONE_P   = P'(1'b1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1'b1);

    // Position of data bit j: the j-th integer >= 3 that is not a power of two.
    // Positions never exceed CW-1, so P bits always hold them.
    function automatic logic [P-1:0] data_pos(input int j);
        logic [P-1:0] pos;
        pos = P'(2'd2);
        for (int k = 32'sd0; k <= j; k++) begin
            pos = pos + ONE_P;
            if ((pos & (pos - ONE_P)) == '0) begin
                pos = pos + ONE_P;
            end else begin
                pos = pos;
            end
        end
        return pos;
    endfunction

    // Hamming parity: p[i] covers every data bit whose position has bit i set.
    function automatic logic [P-1:0] hamming_parity(input logic [DATA_WIDTH-1:0] d);
        logic [P-1:0] par;
        logic [P-1:0] pos;
        par = '0;
        for (int j = 32'sd0; j < DATA_WIDTH; j++) begin
            pos = data_pos(j);
            for (int i = 32'sd0; i < P; i++) begin
                if (pos[i]) begin
                    par[i] = par[i] ^ d[j];
                end else begin
                    par[i] = par[i];
                end
            end
        end
        return par;
    endfunction

    // Full codeword {overall, p, data}; the overall bit makes the word even parity.
    function automatic logic [CW-1:0] encode(input logic [DATA_WIDTH-1:0] d);
        logic [P-1:0] par;
        par = hamming_parity(d);
        return {^{par, d}, par, d};
    endfunction

    logic                  s1_valid_r;
    logic [1:0]            s1_mode_r;
    logic [CW-1:0]         s1_cw_r;
    logic [CW-1:0]         s1_cw_next_s;
    logic                  out_valid_r;
    logic [CW-1:0]         out_data_r;
    logic [1:0]            out_err_r;
    logic [CNT_WIDTH-1:0]  cnt_single_r;
    logic [CNT_WIDTH-1:0]  cnt_double_r;
    logic                  s2_adv_s;
    logic [P-1:0]          syn_s;
    logic                  glob_s;
    logic [DATA_WIDTH-1:0] raw_s;
    logic [DATA_WIDTH-1:0] flip_s;
    logic                  hit_s;
    logic [CW-1:0]         dec_data_s;
    logic [1:0]            dec_err_s;

    assign s2_adv_s       = !out_valid_r || out_ready;
    assign in_ready       = !s1_valid_r || s2_adv_s;
    assign out_valid      = out_valid_r;
    assign out_data       = out_data_r;
    assign out_num_errors = out_err_r;
    assign cnt_single     = cnt_single_r;
    assign cnt_double     = cnt_double_r;

    // Stage-1 word: fresh codeword, received codeword, or codeword with channel noise.
    always_comb begin
        s1_cw_next_s = '0;
        case (in_mode)
            MODE_ENC:  s1_cw_next_s = encode(in_data[DATA_WIDTH-1:0]);
            MODE_DEC:  s1_cw_next_s = in_data;
            MODE_FULL: s1_cw_next_s = encode(in_data[DATA_WIDTH-1:0]) ^ in_noise;
            default:   s1_cw_next_s = '0;
        endcase
    end

    // Stage 1 register: loads whenever it is empty or draining into stage 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_mode_r  <= 2'b00;
            s1_cw_r    <= '0;
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_mode_r <= in_mode;
                s1_cw_r   <= s1_cw_next_s;
            end
        end
    end

    // Syndrome, global parity and the single-bit correction mask for stage 1's word.
    always_comb begin
        raw_s  = s1_cw_r[DATA_WIDTH-1:0];
        syn_s  = hamming_parity(raw_s) ^ s1_cw_r[DATA_WIDTH+P-1:DATA_WIDTH];
        glob_s = ^s1_cw_r;
        flip_s = '0;
        for (int j = 32'sd0; j < DATA_WIDTH; j++) begin
            flip_s[j] = (data_pos(j) == syn_s);
        end
        hit_s = |flip_s;
    end

    // Classify the error and choose the stage-2 payload for each mode.
    always_comb begin
        dec_data_s = '0;
        dec_err_s  = ERR_NONE;
        case (s1_mode_r)
            MODE_ENC: begin
                dec_data_s = s1_cw_r;
                dec_err_s  = ERR_NONE;
            end
            MODE_DEC, MODE_FULL: begin
                if (!glob_s) begin
                    // Even parity: either clean or an uncorrectable pair.
                    dec_data_s = {{(P+1){1'b0}}, raw_s};
                    dec_err_s  = (syn_s == '0) ? ERR_NONE : ERR_DOUBLE;
                end else if ((syn_s & (syn_s - ONE_P)) == '0) begin
                    // Zero or power-of-two syndrome: the flip hit a parity bit.
                    dec_data_s = {{(P+1){1'b0}}, raw_s};
                    dec_err_s  = ERR_SINGLE;
                end else if (hit_s) begin
                    dec_data_s = {{(P+1){1'b0}}, raw_s ^ flip_s};
                    dec_err_s  = ERR_SINGLE;
                end else begin
                    // Odd parity but syndrome points past the codeword.
                    dec_data_s = {{(P+1){1'b0}}, raw_s};
                    dec_err_s  = ERR_DOUBLE;
                end
            end
            default: begin
                dec_data_s = '0;
                dec_err_s  = ERR_RSV;
            end
        endcase
    end

    // Stage 2 / output register: holds its beat while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_err_r   <= 2'b00;
        end else if (s2_adv_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_data_r <= dec_data_s;
                out_err_r  <= dec_err_s;
            end
        end
    end

    // Saturating error statistics, counted on the output handshake; clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_single_r <= '0;
            cnt_double_r <= '0;
        end else if (cnt_clear) begin
            cnt_single_r <= '0;
            cnt_double_r <= '0;
        end else if (out_valid_r && out_ready) begin
            if ((out_err_r == ERR_SINGLE) && (cnt_single_r != '1)) begin
                cnt_single_r <= cnt_single_r + CNT_ONE;
            end
            if ((out_err_r == ERR_DOUBLE) && (cnt_double_r != '1)) begin
                cnt_double_r <= cnt_double_r + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_ecc_secded_stream.sv
// Bench for ecc_secded_stream: a 4-bit/2-bit-counter instance and a 32-bit instance,
// table-driven vectors plus hand-written stall, saturation and reset sequences,
// checked through per-instance expected-result queues.
module tb_ecc_secded_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       in_valid_a, in_ready_a, out_valid_a, out_ready_a, cnt_clear_a;
    logic [1:0] in_mode_a, out_err_a, cnt_single_a, cnt_double_a;
    logic [7:0] in_data_a, in_noise_a, out_data_a;

    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, cnt_clear_b;
    logic [1:0]  in_mode_b, out_err_b;
    logic [38:0] in_data_b, in_noise_b, out_data_b;
    logic [15:0] cnt_single_b, cnt_double_b;

    ecc_secded_stream #(.DATA_WIDTH(4), .CNT_WIDTH(2)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_mode(in_mode_a), .in_data(in_data_a), .in_noise(in_noise_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .out_num_errors(out_err_a), .cnt_clear(cnt_clear_a),
        .cnt_single(cnt_single_a), .cnt_double(cnt_double_a));

    ecc_secded_stream #(.DATA_WIDTH(32), .CNT_WIDTH(16)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_mode(in_mode_b), .in_data(in_data_b), .in_noise(in_noise_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_num_errors(out_err_b), .cnt_clear(cnt_clear_b),
        .cnt_single(cnt_single_b), .cnt_double(cnt_double_b));

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  err;
    } exp_t;

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] data;
        logic [7:0] noise;
        logic [7:0] exp_data;
        logic [1:0] exp_err;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t cur_a, cur_b;
    int   acc_a = 0;
    int   acc_b = 0;
    int   total = 0;
    int   bad = 0;
    int   saw_stall_a = 0;
    logic bp_en = 1'b0;
    logic ready_req_a = 1'b1;
    vec_t tbl [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoder for the 32-bit instance: parity = XOR of positions of set bits.
    function automatic logic [38:0] enc32(input logic [31:0] d);
        logic [5:0] p;
        int pos;
        p = 6'd0;
        pos = 2;
        for (int j = 0; j < 32; j++) begin
            pos++;
            if ((pos & (pos - 1)) == 0) pos++;
            if (d[j]) p = p ^ pos[5:0];
        end
        return {^{p, d}, p, d};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // out_ready for instance a: a 1,0,0,1 pattern during backpressure, else requested level.
    initial begin : ready_drv
        int cyc;
        logic [3:0] pat;
        pat = 4'b1001;
        cyc = 0;
        out_ready_a = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (bp_en) begin
                out_ready_a = pat[cyc % 4];
                cyc++;
            end else begin
                out_ready_a = ready_req_a;
            end
        end
    end

    // Monitor/scoreboard for instance a.
    initial begin : mon_a
        forever begin
            @(negedge clk);
            if (rst) begin
                q_a.delete();
            end else begin
                check("in_ready_a", in_ready_a, !(q_a.size() == 2 && !out_ready_a));
                if (!in_ready_a) saw_stall_a++;
                if (out_valid_a) begin
                    if (q_a.size() == 0) begin
                        check("spurious_out_valid_a", out_valid_a, 0);
                    end else begin
                        check("out_data_a", out_data_a, q_a[0].data);
                        check("out_err_a", out_err_a, q_a[0].err);
                        if (out_ready_a) void'(q_a.pop_front());
                    end
                end
                if (in_valid_a && in_ready_a) begin
                    q_a.push_back(cur_a);
                    acc_a++;
                end
            end
        end
    end

    // Monitor/scoreboard for instance b.
    initial begin : mon_b
        forever begin
            @(negedge clk);
            if (rst) begin
                q_b.delete();
            end else begin
                check("in_ready_b", in_ready_b, !(q_b.size() == 2 && !out_ready_b));
                if (out_valid_b) begin
                    if (q_b.size() == 0) begin
                        check("spurious_out_valid_b", out_valid_b, 0);
                    end else begin
                        check("out_data_b", out_data_b, q_b[0].data);
                        check("out_err_b", out_err_b, q_b[0].err);
                        if (out_ready_b) void'(q_b.pop_front());
                    end
                end
                if (in_valid_b && in_ready_b) begin
                    q_b.push_back(cur_b);
                    acc_b++;
                end
            end
        end
    end

    task automatic send_a(input logic [1:0] m, input logic [7:0] d, input logic [7:0] n,
                          input logic [63:0] ed, input logic [1:0] ee);
        int start;
        int k;
        in_mode_a = m; in_data_a = d; in_noise_a = n;
        cur_a.data = ed; cur_a.err = ee;
        in_valid_a = 1'b1;
        start = acc_a;
        k = 0;
        while (acc_a == start && k < 64) begin tick; k++; end
        in_valid_a = 1'b0;
        if (acc_a == start) check("accept_timeout_a", acc_a, start + 1);
    endtask

    task automatic send_b(input logic [1:0] m, input logic [38:0] d, input logic [38:0] n,
                          input logic [63:0] ed, input logic [1:0] ee);
        int start;
        int k;
        in_mode_b = m; in_data_b = d; in_noise_b = n;
        cur_b.data = ed; cur_b.err = ee;
        in_valid_b = 1'b1;
        start = acc_b;
        k = 0;
        while (acc_b == start && k < 64) begin tick; k++; end
        in_valid_b = 1'b0;
        if (acc_b == start) check("accept_timeout_b", acc_b, start + 1);
    endtask

    task automatic drain_a;
        int k;
        k = 0;
        while (q_a.size() != 0 && k < 64) begin tick; k++; end
        check("drain_a", q_a.size(), 0);
    endtask

    task automatic drain_b;
        int k;
        k = 0;
        while (q_b.size() != 0 && k < 64) begin tick; k++; end
        check("drain_b", q_b.size(), 0);
    endtask

    task automatic clear_a;
        cnt_clear_a = 1'b1;
        tick;
        cnt_clear_a = 1'b0;
        check("clear_single_a", cnt_single_a, 0);
        check("clear_double_a", cnt_double_a, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int exp_s;
        int exp_d;
        int acc0;
        int r1;
        int r2;
        int bp_idx [8];
        logic [31:0] x;
        logic [38:0] one;
        logic [38:0] nz;

        //           mode   data   noise  exp    err
        tbl[0]  = '{2'b00, 8'h0B, 8'h00, 8'h1B, 2'b00};
        tbl[1]  = '{2'b01, 8'h19, 8'h00, 8'h0B, 2'b01};
        tbl[2]  = '{2'b01, 8'h0B, 8'h00, 8'h0B, 2'b01};
        tbl[3]  = '{2'b10, 8'h0B, 8'h03, 8'h08, 2'b10};
        tbl[4]  = '{2'b10, 8'h0B, 8'h00, 8'h0B, 2'b00};
        tbl[5]  = '{2'b11, 8'h5A, 8'h00, 8'h00, 2'b11};
        tbl[6]  = '{2'b01, 8'h1B, 8'h00, 8'h0B, 2'b00};
        tbl[7]  = '{2'b01, 8'h9B, 8'h00, 8'h0B, 2'b01};
        tbl[8]  = '{2'b00, 8'h0F, 8'h00, 8'hFF, 2'b00};
        tbl[9]  = '{2'b01, 8'hFE, 8'h00, 8'h0F, 2'b01};
        tbl[10] = '{2'b00, 8'h00, 8'h00, 8'h00, 2'b00};
        tbl[11] = '{2'b10, 8'h0F, 8'h80, 8'h0F, 2'b01};
        tbl[12] = '{2'b00, 8'hF5, 8'h00, 8'h55, 2'b00};
        tbl[13] = '{2'b01, 8'h18, 8'h00, 8'h08, 2'b10};
        bp_idx = '{1, 2, 6, 7, 9, 13, 1, 2};

        rst = 1'b1;
        in_valid_a = 1'b0; in_mode_a = 2'b00; in_data_a = 8'h00; in_noise_a = 8'h00; cnt_clear_a = 1'b0;
        in_valid_b = 1'b0; in_mode_b = 2'b00; in_data_b = '0; in_noise_b = '0; cnt_clear_b = 1'b0;
        out_ready_b = 1'b1;
        repeat (3) tick;
        rst = 1'b0;

        // Reset state
        check("rst_out_valid_a", out_valid_a, 0);
        check("rst_out_data_a", out_data_a, 0);
        check("rst_out_err_a", out_err_a, 0);
        check("rst_cnt_single_a", cnt_single_a, 0);
        check("rst_cnt_double_a", cnt_double_a, 0);
        check("rst_in_ready_a", in_ready_a, 1);
        check("rst_out_valid_b", out_valid_b, 0);
        check("rst_in_ready_b", in_ready_b, 1);

        // Two-cycle latency on an encode beat
        send_a(2'b00, 8'h0B, 8'h00, 64'h1B, 2'b00);
        check("lat_cycle1_a", out_valid_a, 0);
        tick;
        check("lat_cycle2_a", out_valid_a, 1);
        drain_a;

        // First single-error decode moves cnt_single from 0 to 1
        send_a(2'b01, 8'h19, 8'h00, 64'h0B, 2'b01);
        drain_a;
        check("cnt_single_first_a", cnt_single_a, 1);

        // Table vectors, back to back
        clear_a;
        exp_s = 0;
        exp_d = 0;
        acc0 = acc_a;
        for (int i = 0; i < 14; i++) begin
            send_a(tbl[i].mode, tbl[i].data, tbl[i].noise, {56'd0, tbl[i].exp_data}, tbl[i].exp_err);
            if (tbl[i].exp_err == 2'b01) exp_s++;
            if (tbl[i].exp_err == 2'b10) exp_d++;
        end
        drain_a;
        check("tbl_accepted_a", acc_a - acc0, 14);
        check("tbl_cnt_single_a", cnt_single_a, (exp_s > 3) ? 3 : exp_s);
        check("tbl_cnt_double_a", cnt_double_a, (exp_d > 3) ? 3 : exp_d);

        // Back-to-back decode stream under 1,0,0,1 backpressure
        saw_stall_a = 0;
        acc0 = acc_a;
        bp_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_a(tbl[bp_idx[i]].mode, tbl[bp_idx[i]].data, tbl[bp_idx[i]].noise,
                   {56'd0, tbl[bp_idx[i]].exp_data}, tbl[bp_idx[i]].exp_err);
        end
        bp_en = 1'b0;
        drain_a;
        check("bp_accepted_a", acc_a - acc0, 8);
        check("bp_saw_full_stall_a", saw_stall_a > 0, 1);

        // Saturation at 3, then clear wins over the 5th increment
        clear_a;
        for (int k = 1; k <= 4; k++) begin
            send_a(2'b01, 8'h19, 8'h00, 64'h0B, 2'b01);
            drain_a;
            check("sat_cnt_single_a", cnt_single_a, (k > 3) ? 3 : k);
        end
        send_a(2'b01, 8'h19, 8'h00, 64'h0B, 2'b01);
        tick;
        check("sat5_out_valid_a", out_valid_a, 1);
        cnt_clear_a = 1'b1;
        tick;
        cnt_clear_a = 1'b0;
        check("clear_wins_a", cnt_single_a, 0);
        check("sat5_delivered_a", q_a.size(), 0);

        // Reset with both stages full and stalled
        send_a(2'b01, 8'h19, 8'h00, 64'h0B, 2'b01);
        send_a(2'b01, 8'h18, 8'h00, 64'h08, 2'b10);
        drain_a;
        check("pre_rst_single_a", cnt_single_a, 1);
        check("pre_rst_double_a", cnt_double_a, 1);
        ready_req_a = 1'b0;
        send_a(2'b00, 8'h0B, 8'h00, 64'h1B, 2'b00);
        send_a(2'b00, 8'h0F, 8'h00, 64'hFF, 2'b00);
        check("full_stall_in_ready_a", in_ready_a, 0);
        check("full_stall_out_valid_a", out_valid_a, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        ready_req_a = 1'b1;
        check("mid_rst_out_valid_a", out_valid_a, 0);
        check("mid_rst_single_a", cnt_single_a, 0);
        check("mid_rst_double_a", cnt_double_a, 0);
        check("mid_rst_in_ready_a", in_ready_a, 1);
        send_a(2'b01, 8'h19, 8'h00, 64'h0B, 2'b01);
        drain_a;

        // 32-bit instance: encode, single flips, double flips, out-of-range syndrome
        x = 32'h0155_5555;
        one = 39'd1;
        send_b(2'b00, {7'd0, x}, '0, {25'd0, enc32(x)}, 2'b00);
        for (int k = 0; k < 3; k++) begin
            r1 = int'($urandom_range(38, 0));
            send_b(2'b01, enc32(x) ^ (one << r1), '0, {32'd0, x}, 2'b01);
        end
        r1 = int'($urandom_range(38, 0));
        send_b(2'b10, {7'd0, x}, one << r1, {32'd0, x}, 2'b01);
        r2 = (r1 + int'($urandom_range(38, 1))) % 39;
        nz = (one << r1) | (one << r2);
        send_b(2'b10, {7'd0, x}, nz, {32'd0, x ^ nz[31:0]}, 2'b10);
        send_b(2'b01, enc32(x) ^ (39'h7 << 35), '0, {32'd0, x}, 2'b10);
        send_b(2'b01, enc32(x), '0, {32'd0, x}, 2'b00);
        send_b(2'b11, {7'd0, x}, '0, 64'd0, 2'b11);
        drain_b;
        check("cnt_single_b", cnt_single_b, 4);
        check("cnt_double_b", cnt_double_b, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
